// File: rtl/sram_access_arbiter_if.sv
// Signal bundle between sram_access_arbiter, its two requesters and the SRAM pins.
// The slave modport is the arbiter's view; the master modport is the requester/SRAM side.
interface sram_access_arbiter_if;
    logic        cmd_req;
    logic        cmd_we;
    logic [18:0] cmd_adr;
    logic [15:0] cmd_wdata;
    logic        cmd_ack;
    logic [15:0] cmd_rdata;
    logic        cap_start;
    logic        cap_en;
    logic        strm_valid;
    logic [15:0] strm_data;
    logic        strm_ready;
    logic [19:0] cap_count;
    logic        cap_full;
    logic        busy;
    logic [18:0] sram_adr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;
    logic        sram_ce_n;
    logic        sram_we_n;
    logic        sram_oe_n;

    modport slave (
        input  cmd_req, cmd_we, cmd_adr, cmd_wdata, cap_start, cap_en,
               strm_valid, strm_data, sram_dq_i,
        output cmd_ack, cmd_rdata, strm_ready, cap_count, cap_full, busy,
               sram_adr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n
    );

    modport master (
        output cmd_req, cmd_we, cmd_adr, cmd_wdata, cap_start, cap_en,
               strm_valid, strm_data, sram_dq_i,
        input  cmd_ack, cmd_rdata, strm_ready, cap_count, cap_full, busy,
               sram_adr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Async SRAM sequencer shared round-robin between the command port and the capture stream.
// Define SRAM_CAPTURE_WRAP_EN to make the capture address wrap instead of stopping when full.
//
// state  | meaning
// IDLE   | strobes inactive, grant decision
// SETUP  | ce_n low, address (and write data) driven, oe_n low for reads
// ACCESS | WAIT_CYCLES cycles of we_n (write) or oe_n (read) low
// HOLD   | strobes released, address/data held, ack / capture counters update
module sram_access_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 524288
) (
    input logic                  clk,
    input logic                  rst_n,
    sram_access_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
    typedef enum logic {GNT_CMD = 1'b0, GNT_STREAM = 1'b1} grant_t;

    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [18:0] LAST_ADR  = 19'(DEPTH - 1);
    localparam logic [19:0] DEPTH_W   = 20'(DEPTH);

    state_t      state_q;
    grant_t      last_grant_q;
    logic        is_cmd_q;
    logic        is_wr_q;
    logic [3:0]  wait_q;
    logic [18:0] adr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        ce_n_q;
    logic        we_n_q;
    logic        oe_n_q;
    logic        dq_oe_q;
    logic        ack_q;
    logic [18:0] cap_adr_q;
    logic [19:0] cap_count_q;
    logic        cap_full_q;
    logic        cap_drop_q;

    logic strm_ready;
    logic grant_strm;
    logic grant_cmd;
    logic cap_inc;

    // A waiting command blocks the stream only when the stream had the last grant.
    assign strm_ready = (state_q == IDLE) && bus.cap_en && !cap_full_q &&
                        !(bus.cmd_req && (last_grant_q == GNT_STREAM));
    assign grant_strm = bus.strm_valid && strm_ready;
    assign grant_cmd  = (state_q == IDLE) && bus.cmd_req && !grant_strm;
    assign cap_inc    = (state_q == ACCESS) && (wait_q == 4'd0) && !is_cmd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_STREAM;
            is_cmd_q     <= 1'b0;
            is_wr_q      <= 1'b0;
            wait_q       <= 4'd0;
            adr_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ce_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            dq_oe_q      <= 1'b0;
            ack_q        <= 1'b0;
            cap_adr_q    <= '0;
            cap_count_q  <= '0;
            cap_full_q   <= 1'b0;
            cap_drop_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_strm || grant_cmd) begin
                        state_q      <= SETUP;
                        is_cmd_q     <= grant_cmd;
                        is_wr_q      <= grant_strm | bus.cmd_we;
                        adr_q        <= grant_strm ? (bus.cap_start ? '0 : cap_adr_q) : bus.cmd_adr;
                        wdata_q      <= grant_strm ? bus.strm_data : bus.cmd_wdata;
                        last_grant_q <= grant_strm ? GNT_STREAM : GNT_CMD;
                        ce_n_q       <= 1'b0;
                        dq_oe_q      <= grant_strm | bus.cmd_we;
                        oe_n_q       <= !(grant_cmd && !bus.cmd_we);
                        cap_drop_q   <= 1'b0;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    wait_q  <= WAIT_LOAD;
                    we_n_q  <= !is_wr_q;
                end
                ACCESS: begin
                    if (wait_q == 4'd0) begin
                        state_q <= HOLD;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        ack_q   <= is_cmd_q;
                        if (is_cmd_q && !is_wr_q) begin
                            rdata_q <= bus.sram_dq_i;
                        end
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                HOLD: begin
                    state_q <= IDLE;
                    ce_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            // A restart while a stream write is in flight lets the write finish uncounted.
            if (bus.cap_start && (state_q != IDLE) && !is_cmd_q) begin
                cap_drop_q <= 1'b1;
            end

            if (bus.cap_start) begin
                cap_adr_q   <= '0;
                cap_count_q <= '0;
                cap_full_q  <= 1'b0;
            end else if (cap_inc && !cap_drop_q) begin
`ifdef SRAM_CAPTURE_WRAP_EN
                cap_adr_q <= (cap_adr_q == LAST_ADR) ? '0 : cap_adr_q + 19'd1;
`else
                cap_adr_q <= cap_adr_q + 19'd1;
                if (cap_adr_q == LAST_ADR) begin
                    cap_full_q <= 1'b1;
                end
`endif
                if (cap_count_q != DEPTH_W) begin
                    cap_count_q <= cap_count_q + 20'd1;
                end
            end
        end
    end

    assign bus.cmd_ack    = ack_q;
    assign bus.cmd_rdata  = rdata_q;
    assign bus.strm_ready = strm_ready;
    assign bus.cap_count  = cap_count_q;
    assign bus.cap_full   = cap_full_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.sram_adr   = adr_q;
    assign bus.sram_dq_o  = wdata_q;
    assign bus.sram_dq_oe = dq_oe_q;
    assign bus.sram_ce_n  = ce_n_q;
    assign bus.sram_we_n  = we_n_q;
    assign bus.sram_oe_n  = oe_n_q;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: drivers push expectations, an SRAM-pin monitor pops and checks.
module tb_sram_access_arbiter;
    localparam int W     = 2;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic        we;
        logic [18:0] adr;
        logic [15:0] data;
    } cmd_t;

    typedef struct packed {
        logic [18:0] adr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    sram_access_arbiter_if bus ();

    sram_access_arbiter #(.WAIT_CYCLES(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural SRAM on the pins
    logic [15:0] sram_mem [0:524287];
    assign bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_mem[bus.sram_adr] : 16'h0000;
    always @(posedge bus.sram_we_n) begin
        if (rst_n && !bus.sram_ce_n) sram_mem[bus.sram_adr] = bus.sram_dq_o;
    end

    // Reference model and scoreboard
    cmd_t        cmd_todo [$];
    cmd_t        exp_cmd [$];
    wr_t         exp_strm [$];
    logic [15:0] ref_mem [int];
    bit          grant_log [$];
    int          model_ptr;
    int          model_count;
    bit          model_full;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: required event did not occur (t=%0t)", name, $time);
    endfunction

    function automatic void model_clear();
        model_ptr   = 0;
        model_count = 0;
        model_full  = 1'b0;
    endfunction

    function automatic void model_accept(input logic [15:0] d);
        wr_t w;
        w.adr  = 19'(model_ptr);
        w.data = d;
        exp_strm.push_back(w);
        model_count = (model_count < DEPTH) ? model_count + 1 : DEPTH;
        model_ptr++;
        if (model_ptr == DEPTH) begin
`ifdef SRAM_CAPTURE_WRAP_EN
            model_ptr = 0;
`else
            model_full = 1'b1;
`endif
        end
    endfunction

    function automatic logic [15:0] ref_rd(input logic [18:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
    endfunction

    // Monitor: reconstruct each SRAM access from the pins, compare against the queues
    initial begin : monitor
        bit          in_acc;
        int          len, we_lo, oe_lo, ack_off;
        bit          ack_seen, stable, wr0;
        logic [18:0] adr0;
        logic [15:0] dat0, rd_at_ack;
        cmd_t        c;
        wr_t         w;
        in_acc = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                in_acc = 1'b0;
            end else if (!bus.sram_ce_n) begin
                if (!in_acc) begin
                    in_acc = 1'b1; len = 0; we_lo = 0; oe_lo = 0; ack_off = 0;
                    ack_seen = 1'b0; stable = 1'b1;
                    adr0 = bus.sram_adr; dat0 = bus.sram_dq_o; wr0 = bus.sram_dq_oe;
                end
                if (bus.sram_adr !== adr0 || bus.sram_dq_o !== dat0 || bus.sram_dq_oe !== wr0 || bus.busy !== 1'b1)
                    stable = 1'b0;
                if (!bus.sram_we_n) we_lo++;
                if (!bus.sram_oe_n) oe_lo++;
                if (bus.cmd_ack) begin
                    ack_seen = 1'b1; ack_off = len; rd_at_ack = bus.cmd_rdata;
                end
                len++;
            end else if (in_acc) begin
                in_acc = 1'b0;
                chk("acc_len", len, W + 2);
                chk("we_low_cycles", we_lo, wr0 ? W : 0);
                chk("oe_low_cycles", oe_lo, wr0 ? 0 : W + 1);
                chk("bus_stable", {31'd0, stable}, 1);
                if (ack_seen) begin
                    chk("ack_latency", ack_off, W + 1);
                    grant_log.push_back(1'b0);
                    if (exp_cmd.size() == 0) fail_now("unexpected_cmd_access");
                    else begin
                        c = exp_cmd.pop_front();
                        chk("cmd_dir", {31'd0, wr0}, {31'd0, c.we});
                        chk("cmd_adr", {13'd0, adr0}, {13'd0, c.adr});
                        if (c.we) begin
                            chk("cmd_wdata", {16'd0, dat0}, {16'd0, c.data});
                            ref_mem[int'(c.adr)] = c.data;
                        end else begin
                            chk("cmd_rdata", {16'd0, rd_at_ack}, {16'd0, ref_rd(c.adr)});
                        end
                    end
                end else begin
                    chk("strm_is_write", {31'd0, wr0}, 1);
                    grant_log.push_back(1'b1);
                    if (exp_strm.size() == 0) fail_now("unexpected_strm_access");
                    else begin
                        w = exp_strm.pop_front();
                        chk("strm_adr", {13'd0, adr0}, {13'd0, w.adr});
                        chk("strm_data", {16'd0, dat0}, {16'd0, w.data});
                        ref_mem[int'(w.adr)] = w.data;
                    end
                end
                chk("cap_count", {12'd0, bus.cap_count}, model_count);
                chk("cap_full", {31'd0, bus.cap_full}, {31'd0, model_full});
                chk("busy_idle", {31'd0, bus.busy}, 0);
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_ce_n", {31'd0, bus.sram_ce_n}, 1);
        chk("rst_we_n", {31'd0, bus.sram_we_n}, 1);
        chk("rst_oe_n", {31'd0, bus.sram_oe_n}, 1);
        chk("rst_dq_oe", {31'd0, bus.sram_dq_oe}, 0);
        chk("rst_adr", {13'd0, bus.sram_adr}, 0);
        chk("rst_dq_o", {16'd0, bus.sram_dq_o}, 0);
        chk("rst_ack", {31'd0, bus.cmd_ack}, 0);
        chk("rst_rdata", {16'd0, bus.cmd_rdata}, 0);
        chk("rst_cap_count", {12'd0, bus.cap_count}, 0);
        chk("rst_cap_full", {31'd0, bus.cap_full}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
    endtask

    task automatic cap_start_pulse();
        @(negedge clk);
        bus.cap_start = 1'b1;
        model_clear();
        @(negedge clk);
        bus.cap_start = 1'b0;
    endtask

    task automatic cmd_run(input int budget);
        cmd_t c;
        int   cyc;
        @(negedge clk);
        while (cmd_todo.size() > 0) begin
            c = cmd_todo.pop_front();
            bus.cmd_req   = 1'b1;
            bus.cmd_we    = c.we;
            bus.cmd_adr   = c.adr;
            bus.cmd_wdata = c.data;
            exp_cmd.push_back(c);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!bus.cmd_ack && cyc < budget);
            if (!bus.cmd_ack) begin
                fail_now("cmd_ack_timeout");
                cmd_todo.delete();
            end
        end
        bus.cmd_req = 1'b0;
    endtask

    task automatic stream_burst(input int n, input bit rnd, input logic [15:0] base,
                                input int budget, input bit chk_gap, output int sent);
        int          cyc;
        int          last_acc;
        logic [15:0] d;
        cyc = 0;
        last_acc = -1;
        sent = 0;
        @(negedge clk);
        #2;
        d = rnd ? 16'($urandom) : base;
        bus.strm_valid = 1'b1;
        bus.strm_data  = d;
        while (sent < n && cyc < budget) begin
            if (model_full) chk("ready_when_full", {31'd0, bus.strm_ready}, 0);
            if (bus.strm_ready) begin
                model_accept(d);
                if (chk_gap && last_acc >= 0) chk("ready_spacing", cycle - last_acc, W + 3);
                last_acc = cycle;
                sent++;
                @(negedge clk);
                #2;
                cyc++;
                d = rnd ? 16'($urandom) : base + 16'(sent);
                bus.strm_data = d;
                if (sent == n) bus.strm_valid = 1'b0;
            end else begin
                @(negedge clk);
                #2;
                cyc++;
            end
        end
        bus.strm_valid = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int   sent;
        int   base;
        int   cyc;
        cmd_t c;
        bus.cmd_req = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_wdata = '0;
        bus.cap_start = 1'b0; bus.cap_en = 1'b0; bus.strm_valid = 1'b0; bus.strm_data = '0;
        for (int i = 0; i < 524288; i++) sram_mem[i] = 16'h0000;
        model_clear();

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        // Command write then read-back
        cmd_todo.push_back('{we: 1'b1, adr: 19'h12345, data: 16'hBEEF});
        cmd_todo.push_back('{we: 1'b0, adr: 19'h12345, data: 16'h0000});
        cmd_run(40);
        repeat (3) @(negedge clk);
        chk("rdata_beef", {16'd0, bus.cmd_rdata}, 32'h0000BEEF);

        // Sequential stream burst
        bus.cap_en = 1'b1;
        cap_start_pulse();
        stream_burst(8, 1'b0, 16'h0000, 100, 1'b1, sent);
        chk("burst_sent", sent, 8);
        repeat (8) @(negedge clk);
        chk("burst_count", {12'd0, bus.cap_count}, 8);

        // Random commands interleaved with random samples
        cap_start_pulse();
        for (int i = 0; i < 10; i++) begin
            c.we   = 1'($urandom_range(0, 1));
            c.adr  = 19'h00100 + 19'($urandom_range(0, 5));
            c.data = 16'($urandom);
            cmd_todo.push_back(c);
        end
        fork
            cmd_run(60);
            stream_burst(6, 1'b1, 16'h0000, 300, 1'b0, sent);
        join
        chk("mix_sent", sent, 6);
        repeat (8) @(negedge clk);

        // cap_start landing in a stream HOLD cycle
        cap_start_pulse();
        fork
            stream_burst(3, 1'b1, 16'h0000, 100, 1'b0, sent);
            begin
                cyc = 0;
                do begin @(negedge clk); cyc++; end while (!(!bus.sram_ce_n && !bus.sram_we_n) && cyc < 40);
                do begin @(negedge clk); cyc++; end while (!bus.sram_we_n && cyc < 40);
                if (cyc >= 40) fail_now("hold_detect");
                else begin
                    bus.cap_start = 1'b1;
                    model_clear();
                    @(negedge clk);
                    bus.cap_start = 1'b0;
                end
            end
        join
        chk("hold_start_sent", sent, 3);
        repeat (8) @(negedge clk);
        chk("hold_start_count", {12'd0, bus.cap_count}, 2);

        // End of capture region
        cap_start_pulse();
        stream_burst(20, 1'b0, 16'h1000, 200, 1'b0, sent);
`ifdef SRAM_CAPTURE_WRAP_EN
        chk("region_sent", sent, 20);
`else
        chk("region_sent", sent, 16);
`endif
        repeat (8) @(negedge clk);
        chk("region_count", {12'd0, bus.cap_count}, DEPTH);
        chk("region_full", {31'd0, bus.cap_full}, {31'd0, model_full});

        // Reset in the middle of a write
        @(negedge clk);
        bus.cmd_req = 1'b1; bus.cmd_we = 1'b1; bus.cmd_adr = 19'h00ABC; bus.cmd_wdata = 16'h5A5A;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (bus.sram_we_n && cyc < 20);
        if (bus.sram_we_n) fail_now("write_for_reset");
        #4;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        bus.cmd_req = 1'b0;
        exp_cmd.delete();
        exp_strm.delete();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention after reset: command wins the first tie, then strict alternation
        base = grant_log.size();
        for (int i = 0; i < 4; i++) begin
            c.we = 1'b1; c.adr = 19'h00200 + 19'(i); c.data = 16'($urandom);
            cmd_todo.push_back(c);
        end
        fork
            cmd_run(60);
            stream_burst(4, 1'b1, 16'h0000, 200, 1'b0, sent);
        join
        repeat (8) @(negedge clk);
        if (grant_log.size() < base + 8) fail_now("contention_grants");
        else begin
            for (int i = 0; i < 8; i++) chk("contention_order", {31'd0, grant_log[base + i]}, i % 2);
        end

        repeat (5) @(negedge clk);
        chk("exp_cmd_drained", exp_cmd.size(), 0);
        chk("exp_strm_drained", exp_strm.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
